// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle logic/add/sub plus bit-serial MUL/MULHU and DIV/DIVU/REM/REMU.
// Optional `SEQ_ALU_FLUSH_EN adds a flush input that aborts any in-flight or pending result.
`timescale 1ns/1ps
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef SEQ_ALU_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero_flag
);
    localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b1000, OP_MUL = 4'b1001, OP_MULHU = 4'b1010;
    localparam logic [3:0] OP_DIVU = 4'b1011, OP_REMU = 4'b1100, OP_DIV = 4'b1101, OP_REM = 4'b1110;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               zf_q, zf_d;
    logic               abort;

`ifdef SEQ_ALU_FLUSH_EN
    assign abort = flush;
`else
    assign abort = 1'b0;
`endif

    // Accept-side decode: single-cycle results, including divide corner cases.
    logic             in_is_mul, in_is_div, in_signed, in_div_special;
    logic [WIDTH-1:0] in_a_mag, quick_res;

    assign in_is_mul      = (alu_control == OP_MUL) || (alu_control == OP_MULHU);
    assign in_is_div      = (alu_control == OP_DIVU) || (alu_control == OP_REMU) ||
                            (alu_control == OP_DIV)  || (alu_control == OP_REM);
    assign in_signed      = (alu_control == OP_DIV) || (alu_control == OP_REM);
    assign in_div_special = (in2 == '0) || (in_signed && in1 == MIN_NEG && in2 == '1);
    assign in_a_mag       = (in_signed && in1[WIDTH-1]) ? -in1 : in1;

    always_comb begin
        quick_res = '0;
        case (alu_control)
            OP_AND:           quick_res = in1 & in2;
            OP_OR:            quick_res = in1 | in2;
            OP_ADD:           quick_res = in1 + in2;
            OP_XOR:           quick_res = in1 ^ in2;
            OP_SUB:           quick_res = in1 - in2;
            OP_DIVU, OP_DIV:  quick_res = (in2 == '0) ? '1 : in1;
            OP_REMU, OP_REM:  quick_res = (in2 == '0) ? in1 : '0;
            default:          quick_res = '0;
        endcase
    end

    // Iteration datapath; acc holds {partial product} or {remainder, quotient/dividend}.
    logic             op_signed, a_neg, b_neg, last_iter;
    logic [WIDTH-1:0] b_mag, quo, rem, fix_res;
    logic [WIDTH:0]   msum, dshift, dtrial;
    logic [2*WIDTH-1:0] mul_next, div_next;

    assign op_signed = (op_q == OP_DIV) || (op_q == OP_REM);
    assign a_neg     = op_signed && a_q[WIDTH-1];
    assign b_neg     = op_signed && b_q[WIDTH-1];
    assign b_mag     = b_neg ? -b_q : b_q;
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    assign msum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign mul_next = {msum, acc_q[WIDTH-1:1]};

    assign dshift   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign dtrial   = dshift - {1'b0, b_mag};
    assign div_next = dtrial[WIDTH] ? {dshift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {dtrial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign quo     = acc_q[WIDTH-1:0];
    assign rem     = acc_q[2*WIDTH-1:WIDTH];
    assign fix_res = ((op_q == OP_DIVU) || (op_q == OP_DIV)) ? ((a_neg ^ b_neg) ? -quo : quo)
                                                             : (a_neg ? -rem : rem);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && !abort) begin
                    op_d    = alu_control;
                    a_d     = in1;
                    b_d     = in2;
                    cnt_d   = '0;
                    state_d = S_DONE;
                    res_d   = quick_res;
                    if (in_is_mul) begin
                        state_d = S_MUL;
                        acc_d   = {{WIDTH{1'b0}}, in2};
                    end else if (in_is_div && !in_div_special) begin
                        state_d = S_DIV;
                        acc_d   = {{WIDTH{1'b0}}, in_a_mag};
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    state_d = S_DONE;
                    res_d   = (op_q == OP_MUL) ? mul_next[WIDTH-1:0] : mul_next[2*WIDTH-1:WIDTH];
                end
            end
            S_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) state_d = S_FIX;
            end
            S_FIX: begin
                res_d   = fix_res;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Abort wins over everything, including a same-cycle handshake; the old result is kept.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            res_d   = res_q;
        end
        zf_d = 1'b0;
        if (state_d == S_DONE) zf_d = (state_q == S_DONE) ? zf_q : (res_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            zf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            zf_q    <= zf_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign alu_result = res_q;
    assign zero_flag  = zf_q;
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases, backpressure, reset mid-divide, random ops vs. arithmetic model.
`timescale 1ns/1ps
module tb_seq_alu;
    localparam int W = 32;

    logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [W-1:0]  in1 = '0, in2 = '0;
    logic [3:0]    alu_control = '0;
    logic          in_ready, out_valid, zero_flag;
    logic [W-1:0]  alu_result;
`ifdef SEQ_ALU_FLUSH_EN
    logic          flush = 1'b0;
`endif

    int checks = 0;
    int passed = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef SEQ_ALU_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2),
        .alu_control(alu_control), .out_valid(out_valid), .out_ready(out_ready),
        .alu_result(alu_result), .zero_flag(zero_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    endtask

    // Reference: RV32M-style results using native 64-bit and signed integer arithmetic.
    function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned p;
        int sa, sb;
        p  = {32'b0, a} * {32'b0, b};
        sa = a;
        sb = b;
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0100: return a ^ b;
            4'b1000: return a - b;
            4'b1001: return p[31:0];
            4'b1010: return p[63:32];
            4'b1011: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'b1100: return (b == 0) ? a : a % b;
            4'b1101: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            4'b1110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: return 32'h0;
        endcase
    endfunction

    // Edges from the accept edge (inclusive) until out_valid is first seen.
    function automatic int model_lat(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (op == 4'b1001 || op == 4'b1010) return W + 1;
        if (op >= 4'b1011 && op <= 4'b1110) begin
            if (b == 0) return 1;
            if ((op == 4'b1101 || op == 4'b1110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return W + 2;
        end
        return 1;
    endfunction

    // Present an op, wait for its result; out_ready stays high so the handshake follows at once.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] exp_r;
        int exp_l, n;
        exp_r = model(op, a, b);
        exp_l = model_lat(op, a, b);
        check("in_ready_before", {31'b0, in_ready}, 32'd1);
        alu_control = op; in1 = a; in2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in1 = $urandom; in2 = $urandom; alu_control = 4'($urandom);
        n = 1;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        $display("op=%b a=%h b=%h result=%h expected=%h latency=%0d", op, a, b, alu_result, exp_r, n);
        check("latency", 32'(n), 32'(exp_l));
        check("result", alu_result, exp_r);
        check("zero_flag", {31'b0, zero_flag}, {31'b0, exp_r == 0});
        @(posedge clk); #1;
        check("out_valid_after_hs", {31'b0, out_valid}, 32'd0);
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        logic [3:0] ops [15];
        int seen;
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1001, 4'b1010, 4'b1011,
                4'b1100, 4'b1101, 4'b1110, 4'b0011, 4'b1111, 4'b0110, 4'b1001};

        #2;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", alu_result, 32'd0);
        check("rst_zero_flag", {31'b0, zero_flag}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(4'b0010, 23, 42);
        run_op(4'b1000, 23, 42);
        run_op(4'b1000, 42, 42);
        run_op(4'b0100, 42, 23);
        run_op(4'b1111, 23, 42);
        run_op(4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(4'b1011, 100, 7);
        run_op(4'b1100, 100, 7);
        run_op(4'b1101, 32'hFFFF_FFF9, 2);
        run_op(4'b1110, 32'hFFFF_FFF9, 2);
        run_op(4'b1011, 5, 0);
        run_op(4'b1100, 5, 0);
        run_op(4'b1101, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(4'b1110, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(4'b1001, 23, 42);

        // Backpressure: result held while out_ready is low, new requests ignored.
        out_ready = 1'b0;
        alu_control = 4'b1001; in1 = 3; in2 = 5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 1;
        while (!out_valid && seen < 200) begin
            @(posedge clk); #1;
            seen++;
        end
        check("bp_latency", 32'(seen), 32'(W + 1));
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0]; alu_control = 4'b0010; in1 = 1; in2 = 1;
            @(posedge clk); #1;
            check("bp_result", alu_result, 32'd15);
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        $display("backpressure released: out_valid=%0d in_ready=%0d result=%h", out_valid, in_ready, alu_result);
        check("bp_hs_out_valid", {31'b0, out_valid}, 32'd0);
        check("bp_hs_in_ready", {31'b0, in_ready}, 32'd1);
        check("bp_hs_result_kept", alu_result, 32'd15);
        run_op(4'b0010, 7, 9);

`ifdef SEQ_ALU_FLUSH_EN
        alu_control = 4'b1001; in1 = 6; in2 = 7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        $display("flush mid-MUL: stray out_valid cycles=%0d result=%h", seen, alu_result);
        check("flush_no_out_valid", 32'(seen), 32'd0);
        check("flush_result_kept", alu_result, 32'd16);
`endif

        // Reset during a divide iteration; make the held result nonzero first.
        run_op(4'b1001, 23, 42);
        alu_control = 4'b1011; in1 = 1000; in2 = 3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_result", alu_result, 32'd0);
        check("midrst_zero_flag", {31'b0, zero_flag}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        $display("reset mid-DIV: stray out_valid cycles=%0d", seen);
        check("midrst_no_stale", 32'(seen), 32'd0);

        for (int i = 0; i < 80; i++) begin
            run_op(ops[$urandom_range(0, 14)], rnd_operand(), rnd_operand());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
